debounce_meter: RTL and testbench



---
 rtl/debounce_meter_pkg.sv | 15 +
 rtl/debounce_meter_sync.sv | 22 ++
 rtl/debounce_meter.sv | 166 ++++++++++++++++
 tb/tb_debounce_meter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_meter_pkg.sv
// Shared widths, saturation limit and debounce FSM states for debounce_meter.
// No logic; no latency; no backpressure.
package debounce_meter_pkg;

    localparam int COUNT_W = 32;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        LOW,
        LOW_CHK,
        HIGH,
        HIGH_CHK
    } state_t;

endpackage

// File: rtl/debounce_meter_sync.sv
// Two-flop synchroniser for one asynchronous pin, synchronous active-high reset.
// Latency 2 cycles; no backpressure.
module debounce_meter_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic sync
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

endmodule

// File: rtl/debounce_meter.sv
// Debounces a pin into level/rise/fall and measures pulse high-time (and rise-to-rise period with DEBOUNCE_METER_PERIOD_EN).
// Latency 2+STABLE_CYCLES cycles pin-to-strobe; no backpressure, strobes are single-cycle and must be consumed when seen.
module debounce_meter
    import debounce_meter_pkg::*;
#(
    parameter logic [COUNT_W-1:0] STABLE_CYCLES = 32'd600000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pin,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] width,
    output logic               width_valid,
`ifdef DEBOUNCE_METER_PERIOD_EN
    output logic [COUNT_W-1:0] period,
    output logic               period_valid,
`endif
    output logic               saturated
);

    logic               sync;
    state_t             state;
    logic [COUNT_W-1:0] stable_cnt;
    logic               go_high;
    logic               go_low;
    logic [COUNT_W-1:0] width_cnt;
    logic               width_hit;
    logic               period_hit;

    debounce_meter_sync u_sync (
        .clock (clock),
        .reset (reset),
        .pin   (pin),
        .sync  (sync)
    );

    // stable_cnt holds samples already seen; the current sample makes it +1,
    // so STABLE_CYCLES=1 switches straight from LOW/HIGH.
    always_comb begin
        go_high = 1'b0;
        go_low  = 1'b0;
        case (state)
            LOW:      go_high = sync  && (STABLE_CYCLES == 32'd1);
            LOW_CHK:  go_high = sync  && (stable_cnt == STABLE_CYCLES - 32'd1);
            HIGH:     go_low  = !sync && (STABLE_CYCLES == 32'd1);
            HIGH_CHK: go_low  = !sync && (stable_cnt == STABLE_CYCLES - 32'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= LOW;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            rise <= go_high;
            fall <= go_low;
            case (state)
                LOW: begin
                    if (go_high) begin
                        state <= HIGH;
                        level <= 1'b1;
                    end else if (sync) begin
                        state      <= LOW_CHK;
                        stable_cnt <= 32'd1;
                    end
                end
                LOW_CHK: begin
                    if (!sync) begin
                        state <= LOW;
                    end else if (go_high) begin
                        state <= HIGH;
                        level <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 32'd1;
                    end
                end
                HIGH: begin
                    if (go_low) begin
                        state <= LOW;
                        level <= 1'b0;
                    end else if (!sync) begin
                        state      <= HIGH_CHK;
                        stable_cnt <= 32'd1;
                    end
                end
                HIGH_CHK: begin
                    if (sync) begin
                        state <= HIGH;
                    end else if (go_low) begin
                        state <= LOW;
                        level <= 1'b0;
                    end else begin
                        stable_cnt <= stable_cnt + 32'd1;
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

    // The fall cycle does not count: width_cnt already equals the high-time.
    assign width_hit = level && !go_low && (width_cnt == COUNT_MAX - 32'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            width_cnt   <= '0;
            width       <= '0;
            width_valid <= 1'b0;
        end else begin
            width_valid <= go_low;
            if (go_high) begin
                width_cnt <= 32'd1;
            end else if (level && !go_low && width_cnt != COUNT_MAX) begin
                width_cnt <= width_cnt + 32'd1;
            end
            if (go_low) begin
                width <= width_cnt;
            end
        end
    end

`ifdef DEBOUNCE_METER_PERIOD_EN
    logic [COUNT_W-1:0] period_cnt;
    logic               period_run;

    assign period_hit = period_run && !go_high && (period_cnt == COUNT_MAX - 32'd1);

    // The first rise after reset only arms the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_cnt   <= '0;
            period_run   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= go_high && period_run;
            if (go_high) begin
                if (period_run) begin
                    period <= period_cnt;
                end
                period_cnt <= 32'd1;
                period_run <= 1'b1;
            end else if (period_run && period_cnt != COUNT_MAX) begin
                period_cnt <= period_cnt + 32'd1;
            end
        end
    end
`else
    assign period_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            saturated <= 1'b0;
        end else if (width_hit || period_hit) begin
            saturated <= 1'b1;
        end
    end

endmodule

// File: tb/tb_debounce_meter.sv
// Scoreboard bench: STABLE_CYCLES=4 instance for most scenarios, STABLE_CYCLES=1 instance for the fast path.
module tb_debounce_meter;

    typedef struct {
        logic        is_fall;
        int unsigned cyc;
        logic [31:0] w;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pin4  = 1'b0;
    logic pin1  = 1'b0;

    logic        level4, rise4, fall4, width_valid4, saturated4;
    logic [31:0] width4;
    logic        level1, rise1, fall1, width_valid1, saturated1;
    logic [31:0] width1;
`ifdef DEBOUNCE_METER_PERIOD_EN
    logic [31:0] period4, period1;
    logic        period_valid4, period_valid1;
`endif

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    ev_t         q4[$];
    ev_t         q1[$];
    logic [31:0] qp[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    debounce_meter #(.STABLE_CYCLES(32'd4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .pin          (pin4),
        .level        (level4),
        .rise         (rise4),
        .fall         (fall4),
        .width        (width4),
        .width_valid  (width_valid4),
`ifdef DEBOUNCE_METER_PERIOD_EN
        .period       (period4),
        .period_valid (period_valid4),
`endif
        .saturated    (saturated4)
    );

    debounce_meter #(.STABLE_CYCLES(32'd1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .pin          (pin1),
        .level        (level1),
        .rise         (rise1),
        .fall         (fall1),
        .width        (width1),
        .width_valid  (width_valid1),
`ifdef DEBOUNCE_METER_PERIOD_EN
        .period       (period1),
        .period_valid (period_valid1),
`endif
        .saturated    (saturated1)
    );

    // Event monitors: every strobe must match the head of its scoreboard queue.
    always @(negedge clock) begin
        if (rise4 || fall4 || width_valid4) begin
            tests++;
            if (q4.size() == 0) begin
                fails++;
                $display("FAIL dut4_unexpected_event cyc=%0d rise=%b fall=%b wv=%b required none", cyc, rise4, fall4, width_valid4);
            end else begin
                ev_t e;
                e = q4.pop_front();
                if (rise4 === fall4 || fall4 !== e.is_fall || cyc !== e.cyc ||
                    width_valid4 !== fall4 || (fall4 && width4 !== e.w)) begin
                    fails++;
                    $display("FAIL dut4_event got cyc=%0d rise=%b fall=%b wv=%b width=%h required cyc=%0d fall=%b width=%h",
                             cyc, rise4, fall4, width_valid4, width4, e.cyc, e.is_fall, e.w);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (rise1 || fall1 || width_valid1) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL dut1_unexpected_event cyc=%0d rise=%b fall=%b wv=%b required none", cyc, rise1, fall1, width_valid1);
            end else begin
                ev_t e;
                e = q1.pop_front();
                if (rise1 === fall1 || fall1 !== e.is_fall || cyc !== e.cyc ||
                    width_valid1 !== fall1 || (fall1 && width1 !== e.w)) begin
                    fails++;
                    $display("FAIL dut1_event got cyc=%0d rise=%b fall=%b wv=%b width=%h required cyc=%0d fall=%b width=%h",
                             cyc, rise1, fall1, width_valid1, width1, e.cyc, e.is_fall, e.w);
                end
            end
        end
    end

`ifdef DEBOUNCE_METER_PERIOD_EN
    always @(negedge clock) begin
        if (period_valid4) begin
            tests++;
            if (qp.size() == 0) begin
                fails++;
                $display("FAIL period_unexpected cyc=%0d period=%0d required no period_valid", cyc, period4);
            end else begin
                logic [31:0] p;
                p = qp.pop_front();
                if (period4 !== p || rise4 !== 1'b1) begin
                    fails++;
                    $display("FAIL period got=%0d rise=%b required=%0d with rise", period4, rise4, p);
                end
            end
        end
    end
`endif

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (q4.size() == 0 && q1.size() == 0 && qp.size() == 0) break;
            @(posedge clock);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clock);
        tests++;
        if ({level4, rise4, fall4, width_valid4, saturated4} !== 5'b0 || width4 !== 32'd0) begin
            fails++;
            $display("FAIL reset_dut4 got lvl=%b r=%b f=%b wv=%b sat=%b w=%h required all 0",
                     level4, rise4, fall4, width_valid4, saturated4, width4);
        end
        tests++;
        if ({level1, rise1, fall1, width_valid1, saturated1} !== 5'b0 || width1 !== 32'd0) begin
            fails++;
            $display("FAIL reset_dut1 got lvl=%b r=%b f=%b wv=%b sat=%b w=%h required all 0",
                     level1, rise1, fall1, width_valid1, saturated1, width1);
        end
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_clean_pulse();
        int unsigned c, c2;
        step();
        c = cyc;
        pin4 = 1'b1;
        q4.push_back('{1'b0, c + 6, 32'd0});
        repeat (20) step();
        c2 = cyc;
        pin4 = 1'b0;
        q4.push_back('{1'b1, c2 + 6, 32'd20});
        wait_drain();
        tests++;
        if (q4.size() != 0 || level4 !== 1'b0) begin
            fails++;
            $display("FAIL clean_pulse_drain pending=%0d level=%b required 0 pending, level 0", q4.size(), level4);
        end
    endtask

    task automatic test_glitch();
        step();
        pin4 = 1'b1;
        repeat (3) step();
        pin4 = 1'b0;
        repeat (15) step();
        tests++;
        if (level4 !== 1'b0) begin
            fails++;
            $display("FAIL glitch_level got=%b required=0", level4);
        end
    endtask

    task automatic test_bounce();
        logic [5:0]  train;
        int unsigned c, c2;
        train = 6'b101101;
        c = 0;
        for (int i = 5; i >= 0; i--) begin
            step();
            pin4 = train[i];
            c = cyc;
        end
        q4.push_back('{1'b0, c + 6, 32'd0});
        repeat (30) step();
        c2 = cyc;
        pin4 = 1'b0;
        q4.push_back('{1'b1, c2 + 6, c2 - c});
        wait_drain();
        tests++;
        if (q4.size() != 0) begin
            fails++;
            $display("FAIL bounce_drain pending=%0d required 0", q4.size());
        end
    endtask

    task automatic test_stable1();
        int unsigned c;
        step();
        c = cyc;
        pin1 = 1'b1;
        q1.push_back('{1'b0, c + 3, 32'd0});
        q1.push_back('{1'b1, c + 4, 32'd1});
        step();
        pin1 = 1'b0;
        wait_drain();
        tests++;
        if (q1.size() != 0 || level1 !== 1'b0) begin
            fails++;
            $display("FAIL stable1_drain pending=%0d level=%b required 0 pending, level 0", q1.size(), level1);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int unsigned c, d, c2;
        step();
        c = cyc;
        pin4 = 1'b1;
        q4.push_back('{1'b0, c + 6, 32'd0});
        wait_drain();
        repeat (5) step();
        reset = 1'b1;
        repeat (2) step();
        @(negedge clock);
        tests++;
        if ({level4, rise4, fall4, width_valid4, saturated4} !== 5'b0 || width4 !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_pulse got lvl=%b r=%b f=%b wv=%b sat=%b w=%h required all 0",
                     level4, rise4, fall4, width_valid4, saturated4, width4);
        end
        step();
        reset = 1'b0;
        d = cyc;
        q4.push_back('{1'b0, d + 6, 32'd0});
        wait_drain();
        repeat (4) step();
        c2 = cyc;
        pin4 = 1'b0;
        q4.push_back('{1'b1, c2 + 6, c2 - d});
        wait_drain();
        tests++;
        if (q4.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_pulse_drain pending=%0d required 0", q4.size());
        end
    endtask

    task automatic test_saturation();
        int unsigned c, c2;
        step();
        c = cyc;
        pin4 = 1'b1;
        q4.push_back('{1'b0, c + 6, 32'd0});
        wait_drain();
        @(negedge clock);
        force dut4.width_cnt = 32'hFFFF_FFFD;
        @(negedge clock);
        release dut4.width_cnt;
        repeat (6) step();
        tests++;
        if (saturated4 !== 1'b1) begin
            fails++;
            $display("FAIL saturation_flag got=%b required=1", saturated4);
        end
        c2 = cyc;
        pin4 = 1'b0;
        q4.push_back('{1'b1, c2 + 6, 32'hFFFF_FFFF});
        wait_drain();
        repeat (10) step();
        tests++;
        if (saturated4 !== 1'b1 || width4 !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL saturation_sticky got sat=%b width=%h required sat=1 width=ffffffff", saturated4, width4);
        end
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        tests++;
        if (saturated4 !== 1'b0) begin
            fails++;
            $display("FAIL saturation_clear got=%b required=0", saturated4);
        end
        repeat (4) step();
    endtask

    task automatic test_period();
        int unsigned c;
        for (int p = 0; p < 4; p++) begin
            step();
            c = cyc;
            pin4 = 1'b1;
            q4.push_back('{1'b0, c + 6, 32'd0});
`ifdef DEBOUNCE_METER_PERIOD_EN
            if (p > 0) qp.push_back(32'd15);
`endif
            repeat (8) step();
            pin4 = 1'b0;
            q4.push_back('{1'b1, cyc + 6, 32'd8});
            repeat (6) step();
        end
        wait_drain();
        tests++;
        if (q4.size() != 0 || qp.size() != 0) begin
            fails++;
            $display("FAIL period_drain pending=%0d/%0d required 0/0", q4.size(), qp.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_pulse();
        test_glitch();
        test_bounce();
        test_stable1();
        test_reset_mid_pulse();
        test_saturation();
        test_period();
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
